fb_rect_writer: RTL and testbench
=================================

# fb_rect_writer

Drawing engine that writes the 160x120, 1-bit-per-pixel frame buffer through its write port, upstream of the VGA signal generator. It accepts one drawing command at a time over a valid/ready handshake: clear screen, fill rectangle, set pixel or invert rectangle. It then walks the addressed pixels in raster order and issues one buffer write per pixel, using read-modify-write for invert. Addresses use the same packed format the VGA generator reads: {Y[6:0], X[7:0]}.

## Interface
- FB_W, 160: frame width in pixels; legal X is 0..159.
- FB_H, 120: frame height in pixels; legal Y is 0..119.

- CLK  in  1  system clock; the frame buffer write port is clocked by CLK.
- RESET  in  1  synchronous, active-low reset (low = reset).
- CMD_VALID  in  1  a command is presented.
- CMD_READY  out  1  the engine can accept a command.
- CMD_OP  in  2  operation: 00 clear, 01 fill rect, 10 set pixel, 11 invert rect.
- CMD_X0 / CMD_X1  in  8  rectangle X start and end, inclusive; set pixel uses X0 only.
- CMD_Y0 / CMD_Y1  in  7  rectangle Y start and end, inclusive; set pixel uses Y0 only.
- CMD_VALUE  in  1  pixel value for clear, fill and set pixel; ignored by invert.
- BUF_ADDR  out  15  frame buffer address {Y[6:0], X[7:0]}.
- BUF_WE  out  1  write strobe; one pixel per asserted cycle.
- BUF_WDATA  out  1  write data.
- BUF_RDATA  in  1  read data for BUF_ADDR from the previous cycle (1-cycle latency).
- BUSY  out  1  a command is executing.
- DONE  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, LOAD, FILL, RD, RMW, FINISH.
- IDLE: CMD_READY=1. A handshake (CMD_VALID & CMD_READY at a rising edge) registers all command fields and moves to LOAD. Command inputs are ignored at all other times.
- LOAD: clamp X0/X1 to FB_W-1 and Y0/Y1 to FB_H-1.
  - clear: the rectangle becomes 0..159 x 0..119.
  - set pixel: X1=X0, Y1=Y0.
  - If X0>X1 or Y0>Y1 after clamping, go to FINISH with no writes.
  - Otherwise set cursor (x,y)=(X0,Y0) and go to FILL (ops 00/01/10) or RD (op 11).
- FILL: BUF_WE=1, BUF_ADDR={y,x}, BUF_WDATA=value.
  - Advance x each cycle. At x==X1, wrap x to X0 and increment y.
  - After the write at (X1,Y1), go to FINISH.
- RD: BUF_WE=0, BUF_ADDR={y,x}; go to RMW.
- RMW: BUF_WE=1, same address, BUF_WDATA=~BUF_RDATA. Advance the cursor as in FILL, then return to RD, or go to FINISH after (X1,Y1).
- FINISH: DONE=1 for one cycle, then IDLE.
- Cursor arithmetic: x is 8-bit and y is 7-bit, unsigned. They never exceed the clamped bounds, so no overflow.
- BUSY=1 in LOAD, FILL, RD, RMW and FINISH. CMD_READY = ~BUSY.
- Reset (RESET low at a rising edge), including mid-command: the command is abandoned and the state returns to IDLE.
  - Next cycle: CMD_READY=1, BUSY=0, DONE=0, BUF_WE=0, BUF_ADDR=0, BUF_WDATA=0.
  - No further writes are issued for the abandoned command.

## Timing
- Handshake at edge k: LOAD during cycle k+1. The first write (FILL) or first read (RD) is in cycle k+2.
- Fill/clear/set: N pixels give writes in cycles k+2..k+N+1, DONE in k+N+2, CMD_READY=1 from k+N+3.
- Invert: 2 cycles per pixel; the last write is in cycle k+2N+1 and DONE is in k+2N+2.
- Empty rectangle: DONE in cycle k+2, no BUF_WE.
- Clear takes 19200 writes, so DONE arrives 19202 cycles after the handshake.
- All outputs are registered or decoded from the state register. There are no combinational paths from CMD_* to any output.
- The engine does not gate writes to VGA blanking. Tearing is acceptable.

## Test plan
- Reset: hold RESET low for 3 cycles with CMD_VALID=1 -> CMD_READY=1 after release, BUF_WE=0, DONE=0, BUSY=0.
- Set pixel (x=5, y=3, value 1) -> exactly one write, BUF_ADDR=0x0305, BUF_WDATA=1, DONE 3 cycles after the handshake.
- Fill rect X 10..12, Y 2..3, value 1 -> 6 consecutive writes with addresses 0x020A, 0x020B, 0x020C, 0x030A, 0x030B, 0x030C.
- Clamp and empty cases:
  - X 158..200, Y 119..119 -> writes only at 0x779E and 0x779F.
  - X0=20, X1=10 -> no writes, DONE at k+2.
- Invert X 0..1, Y 0 on a buffer model holding 1,0 -> read/write pairs; the written data is 0, then 1; DONE at k+6.
- Clear (value 0) interrupted by RESET low at write 100 -> no writes after reset, CMD_READY=1. A new set-pixel command is then accepted and completes normally.

Source files
------------

// File: rtl/fb_rect_writer_if.sv
// Command handshake and frame-buffer port bundle for the rectangle drawing engine.
// The slave side belongs to the engine; the master side issues commands and owns the buffer.
interface fb_rect_writer_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [7:0]  CMD_X0;
    logic [7:0]  CMD_X1;
    logic [6:0]  CMD_Y0;
    logic [6:0]  CMD_Y1;
    logic        CMD_VALUE;
    logic [14:0] BUF_ADDR;
    logic        BUF_WE;
    logic        BUF_WDATA;
    logic        BUF_RDATA;
    logic        BUSY;
    logic        DONE;

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_VALUE, BUF_RDATA,
        output CMD_READY, BUF_ADDR, BUF_WE, BUF_WDATA, BUSY, DONE
    );

    modport master (
        output CMD_VALID, CMD_OP, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_VALUE, BUF_RDATA,
        input  CMD_READY, BUF_ADDR, BUF_WE, BUF_WDATA, BUSY, DONE
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Drawing engine for the 160x120 1bpp frame buffer: clear, fill, set pixel and
// invert (read-modify-write), walking the target pixels in raster order.
module fb_rect_writer (
    input  logic               CLK,
    input  logic               RESET,
    fb_rect_writer_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FILL   = 3'd2,
        ST_RD     = 3'd3,
        ST_RMW    = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [7:0] X_MAX = 8'd159;
    localparam logic [6:0] Y_MAX = 7'd119;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        value_q, value_d;
    logic [7:0]  x0_q, x0_d, x1_q, x1_d, x_q, x_d;
    logic [6:0]  y0_q, y0_d, y1_q, y1_d, y_q, y_d;

    logic [7:0]  lx0_s, lx1_s;
    logic [6:0]  ly0_s, ly1_s;
    logic        empty_s;
    logic        last_s;
    logic [7:0]  nx_s;
    logic [6:0]  ny_s;

    // Clamped rectangle bounds for the latched command, used only in LOAD.
    always_comb begin
        lx0_s = (x0_q > X_MAX) ? X_MAX : x0_q;
        lx1_s = (x1_q > X_MAX) ? X_MAX : x1_q;
        ly0_s = (y0_q > Y_MAX) ? Y_MAX : y0_q;
        ly1_s = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        case (op_q)
            2'b00: begin
                lx0_s = 8'd0;
                lx1_s = X_MAX;
                ly0_s = 7'd0;
                ly1_s = Y_MAX;
            end
            2'b10: begin
                lx1_s = lx0_s;
                ly1_s = ly0_s;
            end
            default: begin
                lx1_s = lx1_s;
            end
        endcase
        empty_s = (lx0_s > lx1_s) || (ly0_s > ly1_s);
    end

    // Raster cursor advance: wrap to the left edge at the right edge.
    always_comb begin
        last_s = (x_q == x1_q) && (y_q == y1_q);
        if (x_q == x1_q) begin
            nx_s = x0_q;
            ny_s = y_q + 7'd1;
        end else begin
            nx_s = x_q + 8'd1;
            ny_s = y_q;
        end
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        value_d = value_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CMD_VALID) begin
                    op_d    = bus.CMD_OP;
                    value_d = bus.CMD_VALUE;
                    x0_d    = bus.CMD_X0;
                    x1_d    = bus.CMD_X1;
                    y0_d    = bus.CMD_Y0;
                    y1_d    = bus.CMD_Y1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                x0_d = lx0_s;
                x1_d = lx1_s;
                y0_d = ly0_s;
                y1_d = ly1_s;
                x_d  = lx0_s;
                y_d  = ly0_s;
                if (empty_s) begin
                    state_d = ST_FINISH;
                end else if (op_q == 2'b11) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                x_d     = nx_s;
                y_d     = ny_s;
                state_d = last_s ? ST_FINISH : ST_FILL;
            end
            ST_RD: begin
                state_d = ST_RMW;
            end
            ST_RMW: begin
                x_d     = nx_s;
                y_d     = ny_s;
                state_d = last_s ? ST_FINISH : ST_RD;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            op_q    <= 2'd0;
            value_q <= 1'b0;
            x0_q    <= 8'd0;
            x1_q    <= 8'd0;
            y0_q    <= 7'd0;
            y1_q    <= 7'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            value_q <= value_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Outputs decoded from the state register; invert write data uses last cycle's read.
    always_comb begin
        bus.CMD_READY = (state_q == ST_IDLE);
        bus.BUSY      = (state_q != ST_IDLE);
        bus.DONE      = 1'b0;
        bus.BUF_WE    = 1'b0;
        bus.BUF_ADDR  = 15'd0;
        bus.BUF_WDATA = 1'b0;
        case (state_q)
            ST_FILL: begin
                bus.BUF_WE    = 1'b1;
                bus.BUF_ADDR  = {y_q, x_q};
                bus.BUF_WDATA = value_q;
            end
            ST_RD: begin
                bus.BUF_ADDR  = {y_q, x_q};
            end
            ST_RMW: begin
                bus.BUF_WE    = 1'b1;
                bus.BUF_ADDR  = {y_q, x_q};
                bus.BUF_WDATA = ~bus.BUF_RDATA;
            end
            ST_FINISH: begin
                bus.DONE      = 1'b1;
            end
            default: begin
                bus.BUF_WE    = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed scenarios plus randomized
// commands checked against a pixel-level reference model of the frame buffer.
module tb_fb_rect_writer;
    logic CLK = 1'b0;
    logic RESET;
    fb_rect_writer_if bus();

    fb_rect_writer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    bit mem     [0:32767];
    bit ref_img [0:32767];
    logic        pre_en = 1'b0;
    logic [14:0] pre_addr = 15'd0;
    logic        pre_data = 1'b0;
    int cyc = 0;

    // Frame buffer with 1-cycle read latency, plus a bench back door for preloading.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        bus.BUF_RDATA <= mem[bus.BUF_ADDR];
        if (bus.BUF_WE) mem[bus.BUF_ADDR] <= bus.BUF_WDATA;
        if (pre_en) mem[pre_addr] <= pre_data;
    end

    int n_pass = 0;
    int n_total = 0;

    logic [14:0] obs_addr[$];
    bit          obs_data[$];
    int          obs_rel[$];
    int          done_rel;
    logic [14:0] exp_addr[$];
    bit          exp_data[$];
    int          exp_rel[$];
    int          exp_done;

    // Reference: list of (address, data, cycle offset) for a command, updating ref_img.
    task automatic model_cmd(input int op, input int x0, input int x1, input int y0, input int y1, input bit val);
        int xa, xb, ya, yb, n, a;
        bit d;
        exp_addr.delete(); exp_data.delete(); exp_rel.delete();
        if (op == 0) begin
            xa = 0; xb = 159; ya = 0; yb = 119;
        end else begin
            xa = (x0 > 159) ? 159 : x0;
            xb = (x1 > 159) ? 159 : x1;
            ya = (y0 > 119) ? 119 : y0;
            yb = (y1 > 119) ? 119 : y1;
            if (op == 2) begin xb = xa; yb = ya; end
        end
        n = 0;
        if (xa <= xb && ya <= yb) begin
            for (int y = ya; y <= yb; y++) begin
                for (int x = xa; x <= xb; x++) begin
                    a = y * 256 + x;
                    d = (op == 3) ? ~ref_img[a] : val;
                    ref_img[a] = d;
                    exp_addr.push_back(15'(a));
                    exp_data.push_back(d);
                    exp_rel.push_back((op == 3) ? 3 + 2 * n : 2 + n);
                    n++;
                end
            end
        end
        exp_done = (n == 0) ? 2 : ((op == 3) ? 2 * n + 2 : n + 2);
    endtask

    // Issue one command and record every write with its cycle offset from the handshake.
    task automatic send_cmd(input int op, input int x0, input int x1, input int y0, input int y1,
                            input bit val, input int max_writes);
        int w;
        @(negedge CLK);
        bus.CMD_OP = 2'(op); bus.CMD_X0 = 8'(x0); bus.CMD_X1 = 8'(x1);
        bus.CMD_Y0 = 7'(y0); bus.CMD_Y1 = 7'(y1); bus.CMD_VALUE = val;
        bus.CMD_VALID = 1'b1;
        w = 0;
        while (!bus.CMD_READY && w < 100) begin
            @(negedge CLK);
            w++;
        end
        n_total++;
        if (!bus.CMD_READY) $display("FAIL cmd_ready_wait: got %b expected 1", bus.CMD_READY);
        else n_pass++;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP = 2'($urandom); bus.CMD_X0 = 8'($urandom); bus.CMD_X1 = 8'($urandom);
        bus.CMD_Y0 = 7'($urandom); bus.CMD_Y1 = 7'($urandom); bus.CMD_VALUE = 1'($urandom);
        obs_addr.delete(); obs_data.delete(); obs_rel.delete();
        done_rel = -1;
        for (int j = 1; j <= 25000; j++) begin
            if (bus.BUF_WE) begin
                obs_addr.push_back(bus.BUF_ADDR);
                obs_data.push_back(bus.BUF_WDATA);
                obs_rel.push_back(j);
            end
            if (bus.DONE) begin done_rel = j; break; end
            if (max_writes > 0 && obs_addr.size() >= max_writes) break;
            @(negedge CLK);
        end
    endtask

    task automatic preload(input int a, input bit d);
        @(negedge CLK);
        pre_en = 1'b1; pre_addr = 15'(a); pre_data = d;
        ref_img[a] = d;
        @(negedge CLK);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b01; bus.CMD_X0 = 8'd1; bus.CMD_X1 = 8'd9;
        bus.CMD_Y0 = 7'd1; bus.CMD_Y1 = 7'd9; bus.CMD_VALUE = 1'b1;
        repeat (3) @(negedge CLK);
        n_total++;
        if (bus.BUF_WE !== 1'b0 || bus.BUSY !== 1'b0) $display("FAIL reset_hold: we=%b busy=%b expected 0 0", bus.BUF_WE, bus.BUSY);
        else n_pass++;
        RESET = 1'b1;
        bus.CMD_VALID = 1'b0;
        @(negedge CLK);
        n_total++;
        if ({bus.CMD_READY, bus.BUSY, bus.DONE, bus.BUF_WE} !== 4'b1000) $display("FAIL reset_ctrl: rdy/busy/done/we=%b expected 1000", {bus.CMD_READY, bus.BUSY, bus.DONE, bus.BUF_WE});
        else n_pass++;
        n_total++;
        if (bus.BUF_ADDR !== 15'd0 || bus.BUF_WDATA !== 1'b0) $display("FAIL reset_bus: addr=%h wdata=%b expected 0000 0", bus.BUF_ADDR, bus.BUF_WDATA);
        else n_pass++;
    endtask

    task automatic test_set_pixel();
        model_cmd(2, 5, 77, 3, 99, 1'b1);
        send_cmd(2, 5, 77, 3, 99, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 1) $display("FAIL set_count: got %0d expected 1", obs_addr.size());
        else n_pass++;
        n_total++;
        if (obs_addr.size() < 1 || obs_addr[0] !== 15'h0305 || obs_data[0] !== 1'b1 || obs_rel[0] != 2)
            $display("FAIL set_write: got addr=%h data=%b rel=%0d expected 0305 1 2",
                     (obs_addr.size() > 0) ? obs_addr[0] : 15'h7fff, (obs_data.size() > 0) ? obs_data[0] : 1'b0, (obs_rel.size() > 0) ? obs_rel[0] : -1);
        else n_pass++;
        n_total++;
        if (done_rel != 3) $display("FAIL set_done: got %0d expected 3", done_rel);
        else n_pass++;
        @(negedge CLK);
        n_total++;
        if (bus.CMD_READY !== 1'b1) $display("FAIL set_ready_after: got %b expected 1", bus.CMD_READY);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [14:0] want [6];
        want = '{15'h020A, 15'h020B, 15'h020C, 15'h030A, 15'h030B, 15'h030C};
        model_cmd(1, 10, 12, 2, 3, 1'b1);
        send_cmd(1, 10, 12, 2, 3, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 6) $display("FAIL fill_count: got %0d expected 6", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            n_total++;
            if (obs_addr[i] !== want[i] || obs_data[i] !== 1'b1 || obs_rel[i] != 2 + i)
                $display("FAIL fill_write%0d: got addr=%h data=%b rel=%0d expected %h 1 %0d", i, obs_addr[i], obs_data[i], obs_rel[i], want[i], 2 + i);
            else n_pass++;
        end
        n_total++;
        if (done_rel != 8) $display("FAIL fill_done: got %0d expected 8", done_rel);
        else n_pass++;
    endtask

    task automatic test_clamp_and_empty();
        model_cmd(1, 158, 200, 119, 119, 1'b1);
        send_cmd(1, 158, 200, 119, 119, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 15'h779E || obs_addr[1] !== 15'h779F)
            $display("FAIL clamp_writes: got count=%0d expected 2 at 779e,779f", obs_addr.size());
        else n_pass++;
        n_total++;
        if (done_rel != 4) $display("FAIL clamp_done: got %0d expected 4", done_rel);
        else n_pass++;
        model_cmd(1, 20, 10, 5, 6, 1'b1);
        send_cmd(1, 20, 10, 5, 6, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 0) $display("FAIL empty_writes: got %0d expected 0", obs_addr.size());
        else n_pass++;
        n_total++;
        if (done_rel != 2) $display("FAIL empty_done: got %0d expected 2", done_rel);
        else n_pass++;
    endtask

    task automatic test_invert();
        preload(0, 1'b1);
        preload(1, 1'b0);
        model_cmd(3, 0, 1, 0, 0, 1'b1);
        send_cmd(3, 0, 1, 0, 0, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 15'h0000 || obs_addr[1] !== 15'h0001)
            $display("FAIL inv_addr: got count=%0d expected 2 at 0000,0001", obs_addr.size());
        else n_pass++;
        n_total++;
        if (obs_data.size() != 2 || obs_data[0] !== 1'b0 || obs_data[1] !== 1'b1 || obs_rel[0] != 3 || obs_rel[1] != 5)
            $display("FAIL inv_data: got count=%0d expected data 0,1 at offsets 3,5", obs_data.size());
        else n_pass++;
        n_total++;
        if (done_rel != 6) $display("FAIL inv_done: got %0d expected 6", done_rel);
        else n_pass++;
    endtask

    task automatic test_random();
        int op, x0, x1, y0, y1;
        bit v;
        for (int t = 0; t < 16; t++) begin
            op = $urandom_range(1, 3);
            x0 = $urandom_range(0, 255);
            x1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : x0 + $urandom_range(0, 5);
            if (x1 > 255) x1 = 255;
            y0 = $urandom_range(0, 127);
            y1 = y0 + $urandom_range(0, 3);
            if (y1 > 127) y1 = 127;
            if ($urandom_range(0, 5) == 0 && y0 > 0) y1 = y0 - 1;
            v = 1'($urandom);
            model_cmd(op, x0, x1, y0, y1, v);
            send_cmd(op, x0, x1, y0, y1, v, 0);
            n_total++;
            if (obs_addr.size() != exp_addr.size())
                $display("FAIL rand%0d_count: got %0d expected %0d (op=%0d x=%0d..%0d y=%0d..%0d)", t, obs_addr.size(), exp_addr.size(), op, x0, x1, y0, y1);
            else n_pass++;
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                n_total++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_rel[i] != exp_rel[i])
                    $display("FAIL rand%0d_write%0d: got %h/%b/%0d expected %h/%b/%0d", t, i, obs_addr[i], obs_data[i], obs_rel[i], exp_addr[i], exp_data[i], exp_rel[i]);
                else n_pass++;
            end
            n_total++;
            if (done_rel != exp_done) $display("FAIL rand%0d_done: got %0d expected %0d", t, done_rel, exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        int bad, first_bad;
        model_cmd(0, 7, 3, 9, 2, 1'b1);
        send_cmd(0, 7, 3, 9, 2, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 19200) $display("FAIL clear_count: got %0d expected 19200", obs_addr.size());
        else n_pass++;
        bad = 0; first_bad = -1;
        for (int i = 0; i < 19200 && i < obs_addr.size(); i++) begin
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_rel[i] != exp_rel[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL clear_writes: got %0d bad writes (first %0d) expected 0", bad, first_bad);
        else n_pass++;
        n_total++;
        if (done_rel != 19202) $display("FAIL clear_done: got %0d expected 19202", done_rel);
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int late;
        send_cmd(0, 0, 0, 0, 0, 1'b0, 100);
        n_total++;
        if (obs_addr.size() != 100 || obs_addr[99] !== 15'h0063) $display("FAIL abort_prefix: got count=%0d expected 100 ending at 0063", obs_addr.size());
        else n_pass++;
        RESET = 1'b0;
        @(negedge CLK);
        n_total++;
        if ({bus.CMD_READY, bus.BUSY, bus.DONE, bus.BUF_WE} !== 4'b1000 || bus.BUF_ADDR !== 15'd0 || bus.BUF_WDATA !== 1'b0)
            $display("FAIL abort_reset_state: rdy/busy/done/we=%b addr=%h wdata=%b expected 1000 0000 0",
                     {bus.CMD_READY, bus.BUSY, bus.DONE, bus.BUF_WE}, bus.BUF_ADDR, bus.BUF_WDATA);
        else n_pass++;
        RESET = 1'b1;
        late = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge CLK);
            if (bus.BUF_WE || bus.BUSY) late++;
        end
        n_total++;
        if (late != 0) $display("FAIL abort_no_writes: got %0d active cycles expected 0", late);
        else n_pass++;
        n_total++;
        if (mem[99] !== 1'b0 || mem[100] !== 1'b1) $display("FAIL abort_buffer: got mem99=%b mem100=%b expected 0 1", mem[99], mem[100]);
        else n_pass++;
        send_cmd(2, 7, 0, 9, 0, 1'b1, 0);
        n_total++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 15'h0907 || obs_data[0] !== 1'b1)
            $display("FAIL abort_next_cmd: got count=%0d expected single write 0907=1", obs_addr.size());
        else n_pass++;
        n_total++;
        if (done_rel != 3) $display("FAIL abort_next_done: got %0d expected 3", done_rel);
        else n_pass++;
    endtask

    initial begin
        bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'd0; bus.CMD_X0 = 8'd0; bus.CMD_X1 = 8'd0;
        bus.CMD_Y0 = 7'd0; bus.CMD_Y1 = 7'd0; bus.CMD_VALUE = 1'b0;
        RESET = 1'b0;
        test_reset();
        test_set_pixel();
        test_fill();
        test_clamp_and_empty();
        test_invert();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
